// File: rtl/lsu_mem_stage_if.sv
// +----------------------------------------------------------------------------+
// | lsu_mem_stage_if : execute-side, data-memory and writeback signal bundle   |
// |                    for the load/store memory stage.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lsu_mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_err;

  // Environment side: drives the op, the memory response and writeback ready.
  modport master (
    output ex_valid, alu_result, store_data, mem_read, mem_write, funct3, rd, reg_write,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  wb_valid, wb_data, wb_rd, wb_reg_write, wb_err,
    output wb_ready
  );

  modport slave (
    input  ex_valid, alu_result, store_data, mem_read, mem_write, funct3, rd, reg_write,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output wb_valid, wb_data, wb_rd, wb_reg_write, wb_err,
    input  wb_ready
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_stage.sv
// +----------------------------------------------------------------------------+
// | lsu_mem_stage : RV32I memory-access stage with req/ack data bus, byte      |
// |                 enables, load extension, bus timeout and illegal-op check. |
// | Optional: define MISALIGN_TRAP_EN to fault misaligned half/word accesses.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  lsu_mem_stage_if.slave  bus
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_BUS     = 1'b1;
  localparam bit               C_TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [4:0]       rd_q, rd_d;
  logic             regw_q, regw_d;
  logic             wbv_q, wbv_d;
  logic [31:0]      wbdata_q, wbdata_d;
  logic [4:0]       wbrd_q, wbrd_d;
  logic             wbregw_q, wbregw_d;
  logic             wberr_q, wberr_d;

  logic        w_ex_ready;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_ex_ready = (state_q == S_IDLE) && (!wbv_q || bus.wb_ready);
  assign w_accept   = bus.ex_valid && w_ex_ready;
  assign w_is_mem   = bus.mem_read || bus.mem_write;

  always_comb begin
    w_illegal = 1'b0;
    if (bus.mem_read && bus.mem_write)
      w_illegal = 1'b1;
    else if (bus.mem_read && !(bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      w_illegal = 1'b1;
    else if (bus.mem_write && !(bus.funct3 inside {3'b000, 3'b001, 3'b010}))
      w_illegal = 1'b1;
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.alu_result[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (bus.alu_result[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Low address bits beyond the access size are ignored when alignment isn't trapped.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.store_data;
    case (bus.funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.alu_result[1:0];
        w_wdata = {4{bus.store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {bus.alu_result[1], 1'b0};
        w_wdata = {2{bus.store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = bus.dmem_rdata[7:0];
    case (off_q)
      2'b00:   w_byte = bus.dmem_rdata[7:0];
      2'b01:   w_byte = bus.dmem_rdata[15:8];
      2'b10:   w_byte = bus.dmem_rdata[23:16];
      default: w_byte = bus.dmem_rdata[31:24];
    endcase
    w_half = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    regw_d   = regw_q;
    wbv_d    = wbv_q;
    wbdata_d = wbdata_q;
    wbrd_d   = wbrd_q;
    wbregw_d = wbregw_q;
    wberr_d  = wberr_q;

    if (wbv_q && bus.wb_ready)
      wbv_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_is_mem) begin
            wbv_d    = 1'b1;
            wbdata_d = bus.alu_result;
            wbrd_d   = bus.rd;
            wbregw_d = bus.reg_write;
            wberr_d  = 1'b0;
          end else if (w_illegal) begin
            wbv_d    = 1'b1;
            wbdata_d = 32'd0;
            wbrd_d   = bus.rd;
            wbregw_d = 1'b0;
            wberr_d  = 1'b1;
          end else if (w_misalign) begin
            wbv_d    = 1'b1;
            wbdata_d = bus.alu_result;
            wbrd_d   = bus.rd;
            wbregw_d = 1'b0;
            wberr_d  = 1'b1;
          end else begin
            state_d = S_BUS;
            req_d   = 1'b1;
            we_d    = bus.mem_write;
            addr_d  = {bus.alu_result[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
            cnt_d   = '0;
            f3_d    = bus.funct3;
            off_d   = bus.alu_result[1:0];
            rd_d    = bus.rd;
            regw_d  = bus.reg_write && bus.mem_read;
          end
        end
      end
      default: begin
        if (bus.dmem_ack) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrd_d   = rd_q;
          wberr_d  = 1'b0;
          wbdata_d = we_q ? 32'd0 : w_load;
          wbregw_d = we_q ? 1'b0 : regw_q;
        end else if (C_TO_EN && (cnt_q == C_TO_LAST)) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          wbv_d    = 1'b1;
          wbrd_d   = rd_q;
          wberr_d  = 1'b1;
          wbdata_d = 32'd0;
          wbregw_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= '0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      rd_q     <= 5'd0;
      regw_q   <= 1'b0;
      wbv_q    <= 1'b0;
      wbdata_q <= 32'd0;
      wbrd_q   <= 5'd0;
      wbregw_q <= 1'b0;
      wberr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      regw_q   <= regw_d;
      wbv_q    <= wbv_d;
      wbdata_q <= wbdata_d;
      wbrd_q   <= wbrd_d;
      wbregw_q <= wbregw_d;
      wberr_q  <= wberr_d;
    end
  end

  assign bus.ex_ready     = w_ex_ready;
  assign bus.dmem_req     = req_q;
  assign bus.dmem_we      = we_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_be      = be_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.wb_valid     = wbv_q;
  assign bus.wb_data      = wbdata_q;
  assign bus.wb_rd        = wbrd_q;
  assign bus.wb_reg_write = wbregw_q;
  assign bus.wb_err       = wberr_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
// +----------------------------------------------------------------------------+
// | tb_lsu_mem_stage : directed self-checking bench for lsu_mem_stage.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_stage;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                       input logic rdf, input logic wrf, input logic [4:0] r, input logic rw);
    bus.alu_result = a;
    bus.store_data = sd;
    bus.funct3     = f3;
    bus.mem_read   = rdf;
    bus.mem_write  = wrf;
    bus.rd         = r;
    bus.reg_write  = rw;
    bus.ex_valid   = 1'b1;
    tick();
    bus.ex_valid  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Ack arrives in the k-th cycle that dmem_req is high (k=1: same cycle it rises).
  task automatic ack_in(input int k, input logic [31:0] rdat);
    for (int i = 1; i < k; i++) tick();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdat;
    tick();
    bus.dmem_ack   = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst            = 1'b1;
    bus.ex_valid   = 1'b0;
    bus.alu_result = 32'd0;
    bus.store_data = 32'd0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.funct3     = 3'd0;
    bus.rd         = 5'd0;
    bus.reg_write  = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    bus.wb_ready   = 1'b1;
    tick();
    tick();
    chk("rst_req",    {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_wbv",    {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_err",    {31'd0, bus.wb_err}, 32'd0);
    chk("rst_addr",   bus.dmem_addr, 32'd0);
    chk("rst_wdata",  bus.wb_data, 32'd0);
    chk("rst_exrdy",  {31'd0, bus.ex_ready}, 32'd1);
    rst = 1'b0;
    tick();

    // Non-memory pass-through
    issue(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
    chk("add_wbv",  {31'd0, bus.wb_valid}, 32'd1);
    chk("add_data", bus.wb_data, 32'h0000_1234);
    chk("add_rd",   {27'd0, bus.wb_rd}, 32'd5);
    chk("add_rw",   {31'd0, bus.wb_reg_write}, 32'd1);
    chk("add_err",  {31'd0, bus.wb_err}, 32'd0);
    chk("add_req",  {31'd0, bus.dmem_req}, 32'd0);
    tick();
    chk("add_drain", {31'd0, bus.wb_valid}, 32'd0);

    // Back-to-back non-memory ops, one per cycle
    issue(32'hA5A5_0001, 32'd0, 3'b000, 1'b0, 1'b0, 5'd1, 1'b1);
    chk("b2b_rdy", {31'd0, bus.ex_ready}, 32'd1);
    issue(32'hA5A5_0002, 32'd0, 3'b000, 1'b0, 1'b0, 5'd2, 1'b0);
    chk("b2b_data", bus.wb_data, 32'hA5A5_0002);
    chk("b2b_rw",   {31'd0, bus.wb_reg_write}, 32'd0);
    tick();

    // SB to 0x1003, acked on the 3rd request cycle
    issue(32'h0000_1003, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("sb_req",   {31'd0, bus.dmem_req}, 32'd1);
    chk("sb_we",    {31'd0, bus.dmem_we}, 32'd1);
    chk("sb_addr",  bus.dmem_addr, 32'h0000_1000);
    chk("sb_be",    {28'd0, bus.dmem_be}, 32'h8);
    chk("sb_wdata", bus.dmem_wdata, 32'hDDDD_DDDD);
    chk("sb_exrdy", {31'd0, bus.ex_ready}, 32'd0);
    ack_in(3, 32'hFFFF_FFFF);
    chk("sb_req_off", {31'd0, bus.dmem_req}, 32'd0);
    chk("sb_wbv",     {31'd0, bus.wb_valid}, 32'd1);
    chk("sb_rw",      {31'd0, bus.wb_reg_write}, 32'd0);
    chk("sb_err",     {31'd0, bus.wb_err}, 32'd0);
    chk("sb_data",    bus.wb_data, 32'd0);
    tick();

    // SH to 0x1002
    issue(32'h0000_1002, 32'h1111_ABCD, 3'b001, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("sh_be",    {28'd0, bus.dmem_be}, 32'hC);
    chk("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
    ack_in(1, 32'd0);
    tick();

    // Loads with extension; ack in the cycle req rises (2-cycle latency)
    issue(32'h0000_2001, 32'd0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
    chk("lb_be", {28'd0, bus.dmem_be}, 32'h2);
    chk("lb_we", {31'd0, bus.dmem_we}, 32'd0);
    ack_in(1, 32'h0000_8000);
    chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("lb_rw",   {31'd0, bus.wb_reg_write}, 32'd1);
    chk("lb_rd",   {27'd0, bus.wb_rd}, 32'd7);
    tick();

    issue(32'h0000_2001, 32'd0, 3'b100, 1'b1, 1'b0, 5'd7, 1'b1);
    ack_in(1, 32'h0000_8000);
    chk("lbu_data", bus.wb_data, 32'h0000_0080);
    tick();

    issue(32'h0000_2002, 32'd0, 3'b001, 1'b1, 1'b0, 5'd8, 1'b1);
    chk("lh_be", {28'd0, bus.dmem_be}, 32'hC);
    ack_in(1, 32'h8001_0000);
    chk("lh_data", bus.wb_data, 32'hFFFF_8001);
    tick();

    issue(32'h0000_2000, 32'd0, 3'b101, 1'b1, 1'b0, 5'd8, 1'b1);
    ack_in(2, 32'h1234_F00D);
    chk("lhu_data", bus.wb_data, 32'h0000_F00D);
    tick();

    issue(32'h0000_2004, 32'd0, 3'b010, 1'b1, 1'b0, 5'd9, 1'b1);
    chk("lw_addr", bus.dmem_addr, 32'h0000_2004);
    chk("lw_be",   {28'd0, bus.dmem_be}, 32'hF);
    ack_in(1, 32'hDEAD_BEEF);
    chk("lw_data", bus.wb_data, 32'hDEAD_BEEF);
    tick();

    // Timeout: TIMEOUT_CYCLES=4, never acked
    issue(32'h0000_4000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
    chk("to_req1", {31'd0, bus.dmem_req}, 32'd1);
    tick();
    tick();
    tick();
    chk("to_req4", {31'd0, bus.dmem_req}, 32'd1);
    chk("to_nowb", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    chk("to_req_off", {31'd0, bus.dmem_req}, 32'd0);
    chk("to_wbv",     {31'd0, bus.wb_valid}, 32'd1);
    chk("to_err",     {31'd0, bus.wb_err}, 32'd1);
    chk("to_rw",      {31'd0, bus.wb_reg_write}, 32'd0);
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h5555_5555;
    tick();
    bus.dmem_ack = 1'b0;
    chk("late_ack_wbv", {31'd0, bus.wb_valid}, 32'd0);
    chk("late_ack_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    chk("late_ack_wbv2", {31'd0, bus.wb_valid}, 32'd0);

    // Writeback backpressure
    bus.wb_ready = 1'b0;
    issue(32'h0000_5000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
    ack_in(1, 32'h0102_0304);
    chk("bp_wbv", {31'd0, bus.wb_valid}, 32'd1);
    bus.alu_result = 32'h0000_0077;
    bus.rd         = 5'd9;
    bus.reg_write  = 1'b1;
    bus.funct3     = 3'b000;
    bus.ex_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_exrdy", {31'd0, bus.ex_ready}, 32'd0);
      chk("bp_hold",  bus.wb_data, 32'h0102_0304);
      chk("bp_rd",    {27'd0, bus.wb_rd}, 32'd4);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    chk("bp_rdy_on", {31'd0, bus.ex_ready}, 32'd1);
    tick();
    bus.ex_valid = 1'b0;
    chk("bp_next_data", bus.wb_data, 32'h0000_0077);
    chk("bp_next_rd",   {27'd0, bus.wb_rd}, 32'd9);
    tick();

    // Illegal encodings
    issue(32'h0000_6000, 32'd0, 3'b011, 1'b1, 1'b0, 5'd6, 1'b1);
    chk("ill_ld_err", {31'd0, bus.wb_err}, 32'd1);
    chk("ill_ld_rw",  {31'd0, bus.wb_reg_write}, 32'd0);
    chk("ill_ld_dat", bus.wb_data, 32'd0);
    chk("ill_ld_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    issue(32'h0000_6000, 32'd0, 3'b100, 1'b0, 1'b1, 5'd6, 1'b0);
    chk("ill_st_err", {31'd0, bus.wb_err}, 32'd1);
    chk("ill_st_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();
    issue(32'h0000_6000, 32'd0, 3'b010, 1'b1, 1'b1, 5'd6, 1'b1);
    chk("ill_rw_err", {31'd0, bus.wb_err}, 32'd1);
    chk("ill_rw_req", {31'd0, bus.dmem_req}, 32'd0);
    tick();

    // Misaligned word access
    issue(32'h0000_3002, 32'd0, 3'b010, 1'b1, 1'b0, 5'd10, 1'b1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req",  {31'd0, bus.dmem_req}, 32'd0);
    chk("mis_err",  {31'd0, bus.wb_err}, 32'd1);
    chk("mis_data", bus.wb_data, 32'h0000_3002);
    chk("mis_rw",   {31'd0, bus.wb_reg_write}, 32'd0);
`else
    chk("mis_addr", bus.dmem_addr, 32'h0000_3000);
    chk("mis_be",   {28'd0, bus.dmem_be}, 32'hF);
    ack_in(1, 32'hCAFE_0001);
    chk("mis_err",  {31'd0, bus.wb_err}, 32'd0);
    chk("mis_data", bus.wb_data, 32'hCAFE_0001);
`endif
    tick();

    // Reset while a request is outstanding; ack in that cycle is ignored
    issue(32'h0000_7000, 32'd0, 3'b010, 1'b1, 1'b0, 5'd11, 1'b1);
    chk("rb_req", {31'd0, bus.dmem_req}, 32'd1);
    rst            = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1234_5678;
    tick();
    rst          = 1'b0;
    bus.dmem_ack = 1'b0;
    chk("rb_req_off", {31'd0, bus.dmem_req}, 32'd0);
    chk("rb_wbv",     {31'd0, bus.wb_valid}, 32'd0);
    chk("rb_addr",    bus.dmem_addr, 32'd0);
    tick();
    chk("rb_wbv2",    {31'd0, bus.wb_valid}, 32'd0);
    chk("rb_exrdy",   {31'd0, bus.ex_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory-access stage directly downstream of the execute-stage ALU. Takes the ALU result as the effective address (or as a pass-through writeback value for non-memory ops) and performs RV32I loads/stores on a req/ack data-memory bus. Handles byte-enable generation, store-data lane replication, load extraction and sign/zero extension, bus timeout, and illegal-funct3 detection. Hands results to writeback over a valid/ready pair.

Parameters:
TIMEOUT_CYCLES, 255, max cycles dmem_req stays high without dmem_ack before a bus error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  execute stage presents an op
ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
alu_result  in  32  effective address, or writeback value for non-memory ops
store_data  in  32  rs2 value for stores
mem_read  in  1  load op
mem_write  in  1  store op
funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
rd  in  5  destination register
reg_write  in  1  op writes rd
dmem_req  out  1  bus request; held until ack
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_ack  in  1  bus completion; rdata valid same cycle
dmem_rdata  in  32  read word
wb_valid  out  1  writeback result valid
wb_ready  in  1  writeback accepts; transfer when wb_valid && wb_ready
wb_data  out  32  result
wb_rd  out  5  destination
wb_reg_write  out  1  write enable (forced 0 on stores and errors)
wb_err  out  1  access fault (timeout, illegal op, misalign if enabled)

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, wb_valid, wb_reg_write, wb_err = 0; dmem_addr, dmem_be, dmem_wdata, wb_data, wb_rd = 0; timeout counter = 0.
- ex_ready = (state==IDLE) && (!wb_valid || wb_ready). Combinational; no other path to ex_valid.
- States: IDLE, BUS.
- IDLE, accept of a non-memory op (mem_read=mem_write=0): next cycle wb_valid=1, wb_data=alu_result, wb_rd/wb_reg_write from inputs, wb_err=0. Latency 1. Back-to-back accepts sustain 1 op/cycle while wb_ready=1.
- IDLE, accept with mem_read && mem_write, or a load funct3 not in {000,001,010,100,101}, or a store funct3 not in {000,001,010}: no bus access; next cycle wb_valid=1, wb_err=1, wb_reg_write=0, wb_data=0.
- IDLE, accept of a legal load/store: next cycle state=BUS, dmem_req=1 with dmem_addr/be/we/wdata registered and stable until ack. Counter cleared.
- Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads drive the same be pattern.
- Store data: SB {4{sd[7:0]}}, SH {2{sd[15:0]}}, SW sd.
- BUS, dmem_ack=1: dmem_req=0 next cycle; state=IDLE; wb_valid=1; load: byte/half selected by addr[1:0]/addr[1], sign-extended (LB/LH) or zero-extended (LBU/LHU), LW full word; store: wb_data=0, wb_reg_write=0. Ack in the same cycle req first rises is legal; minimum memory-op latency = 2 cycles accept-to-wb_valid.
- BUS, no ack: counter increments each cycle. When counter reaches TIMEOUT_CYCLES-1 without ack (TIMEOUT_CYCLES>0): drop dmem_req, state=IDLE, wb_valid=1, wb_err=1, wb_reg_write=0. A late ack arriving in IDLE is ignored.
- wb_valid holds with all wb_* stable until wb_ready; stage cannot accept (ex_ready=0) while wb_valid && !wb_ready.
- rst in BUS: request abandoned, all outputs to reset values at that edge; ack in the reset cycle ignored.
- rd=0 passes through unchanged; suppressing x0 writes is the register file's job.

Optional Feature:
MISALIGN_TRAP_EN: defined -> half access with addr[0]=1 or word access with addr[1:0]!=0 issues no bus access; next cycle wb_valid=1, wb_err=1, wb_reg_write=0, wb_data=alu_result (faulting address). Undefined -> ignored low bits: half uses addr[1] only, word ignores addr[1:0]; no error.

Test Plan:
- ADD pass-through alu_result=0x0000_1234, rd=5, reg_write=1 -> 1 cycle later wb_valid=1, wb_data=0x1234, wb_rd=5, no dmem_req.
- SB addr=0x1003, store_data=0xAABBCCDD, ack on 3rd req cycle -> dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, wb_reg_write=0, wb_err=0.
- LB addr=0x2001, rdata=0x0000_8000 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x2002, rdata=0x8001_0000 -> 0xFFFF8001.
- TIMEOUT_CYCLES=4, LW never acked -> req drops after 4 cycles, wb_err=1, wb_reg_write=0; later ack ignored.
- LW completes with wb_ready=0 for 3 cycles -> wb_* stable, ex_ready=0; next op accepted the cycle wb_ready=1.
- LW addr=0x3002: MISALIGN_TRAP_EN defined -> no dmem_req, wb_err=1, wb_data=0x3002; undefined -> dmem_addr=0x3000, be=4'b1111, no error.
